// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and constants for the PC update / exception stage.
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_VEC_REQ  = 2'd1,
        ST_VEC_WAIT = 2'd2,
        ST_VEC_LOAD = 2'd3
    } vec_state_t;

    localparam logic [1:0]  CAUSE_MISALIGN   = 2'd0;
    localparam logic [1:0]  CAUSE_OPCODE     = 2'd1;
    localparam logic [1:0]  CAUSE_OVF        = 2'd2;
    localparam logic [1:0]  CAUSE_DIV0       = 2'd3;
    localparam logic [31:0] VEC_BASE_DEFAULT = 32'd252;
    localparam int          CNT_W            = 3;

    function automatic logic [31:0] vec_entry(input logic [31:0] base, input logic [1:0] cause);
        return base + {30'b0, cause};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_update_unit_if.sv
`default_nettype none
// ============================================================================
// Module : pc_update_unit_if
// Brief  : Control/mux/memory-side bundle of the PC update stage.
// Rev    : 1.0
// ============================================================================
interface pc_update_unit_if;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    logic        alu_zero;
    logic        exc_req;
    logic [1:0]  exc_code;
    logic [7:0]  mem_rdata;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  exc_cause;
    logic        vec_rd;
    logic [31:0] vec_addr;
    logic        exc_busy;

    modport master (
        output pc_next, pc_write, pc_write_cond, branch_ne, alu_zero, exc_req, exc_code, mem_rdata,
        input  pc, epc, exc_cause, vec_rd, vec_addr, exc_busy
    );

    modport slave (
        input  pc_next, pc_write, pc_write_cond, branch_ne, alu_zero, exc_req, exc_code, mem_rdata,
        output pc, epc, exc_cause, vec_rd, vec_addr, exc_busy
    );
endinterface
`default_nettype wire

// File: rtl/exc_vector_fetch.sv
`default_nettype none
// ============================================================================
// Module : exc_vector_fetch
// Brief  : Exception sequencer: issues the vector byte read, waits out the
//          memory latency and signals when the handler byte is to be loaded.
// Rev    : 1.0
// ============================================================================
module exc_vector_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT,
    parameter int          MEM_LAT  = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic [1:0]  cause,
    output logic             vec_rd,
    output logic [31:0]      vec_addr,
    output logic             exc_busy,
    output logic             load
);

    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(MEM_LAT - 1);

    vec_state_t       r_state;
    vec_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        vec_rd      = 1'b0;
        vec_addr    = '0;
        exc_busy    = 1'b1;
        load        = 1'b0;
        case (r_state)
            ST_RUN: begin
                exc_busy = 1'b0;
                if (start) w_state_nxt = ST_VEC_REQ;
            end
            ST_VEC_REQ: begin
                vec_rd      = 1'b1;
                vec_addr    = vec_entry(VEC_BASE, cause);
                w_cnt_nxt   = C_CNT_INIT;
                // A single-cycle memory has nothing to wait for.
                w_state_nxt = (MEM_LAT == 1) ? ST_VEC_LOAD : ST_VEC_WAIT;
            end
            ST_VEC_WAIT: begin
                if (r_cnt == '0) w_state_nxt = ST_VEC_LOAD;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_VEC_LOAD: begin
                load        = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module : pc_update_unit
// Brief  : PC/EPC registers with branch qualification, misaligned-target
//          detection and vectored exception entry.
// Rev    : 1.0
// ============================================================================
module pc_update_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter logic [31:0] EPC_OFFSET = 32'd4,
    parameter int          MEM_LAT    = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    pc_update_unit_if.slave bus
);

    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [1:0]  r_cause;
    logic        w_take;
    logic        w_misalign;
    logic        w_start;
    logic        w_busy;
    logic        w_load;

    assign w_take     = bus.pc_write | (bus.pc_write_cond & (bus.alu_zero ^ bus.branch_ne));
    assign w_misalign = w_take & (bus.pc_next[1:0] != 2'b00);
    assign w_start    = ~w_busy & (bus.exc_req | w_misalign);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_epc   <= '0;
            r_cause <= CAUSE_MISALIGN;
        end else if (w_load) begin
            r_pc <= {24'b0, bus.mem_rdata};
        end else if (!w_busy) begin
            // EPC points back at the faulting instruction; PC was advanced at fetch.
            if (bus.exc_req) begin
                r_epc   <= r_pc - EPC_OFFSET;
                r_cause <= bus.exc_code;
            end else if (w_misalign) begin
                r_epc   <= r_pc - EPC_OFFSET;
                r_cause <= CAUSE_MISALIGN;
            end else if (w_take) begin
                r_pc <= bus.pc_next;
            end
        end
    end

    exc_vector_fetch #(
        .VEC_BASE (VEC_BASE),
        .MEM_LAT  (MEM_LAT)
    ) u_vec_fetch (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .cause    (r_cause),
        .vec_rd   (bus.vec_rd),
        .vec_addr (bus.vec_addr),
        .exc_busy (w_busy),
        .load     (w_load)
    );

    assign bus.pc        = r_pc;
    assign bus.epc       = r_epc;
    assign bus.exc_cause = r_cause;
    assign bus.exc_busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_update_unit
// Brief  : Directed and randomized bench for pc_update_unit (MEM_LAT 2 and 1).
// Rev    : 1.0
// ============================================================================
module tb_pc_update_unit;

    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_update_unit_if bus();
    pc_update_unit_if bus2();

    pc_update_unit #(.MEM_LAT(LAT)) dut  (.clk(clk), .reset(reset), .bus(bus));
    pc_update_unit #(.MEM_LAT(1))   dut1 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    // Vector table memory: bytes at 252..255, indexed by cause.
    logic [7:0] mem_byte [4];
    logic [7:0] rd_q  = 8'h00;
    logic [7:0] rd2_q = 8'h00;
    always @(posedge clk) begin
        if (bus.vec_rd)  rd_q  <= mem_byte[bus.vec_addr[1:0]];
        if (bus2.vec_rd) rd2_q <= mem_byte[bus2.vec_addr[1:0]];
    end
    assign bus.mem_rdata  = rd_q;
    assign bus2.mem_rdata = rd2_q;

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    bit          m_busy;
    int          m_rd_edge, m_load_edge, edge_cnt;

    function automatic void model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'd0; m_busy = 1'b0;
        m_rd_edge = -1; m_load_edge = -1;
    endfunction

    function automatic void start_exc();
        m_busy      = 1'b1;
        m_rd_edge   = edge_cnt;
        m_load_edge = edge_cnt + LAT + 2;
    endfunction

    function automatic bit exp_vec_rd();
        return m_busy && (edge_cnt == m_rd_edge);
    endfunction

    task automatic idle_inputs();
        bus.pc_next = 32'h0; bus.pc_write = 1'b0; bus.pc_write_cond = 1'b0;
        bus.branch_ne = 1'b0; bus.alu_zero = 1'b0; bus.exc_req = 1'b0; bus.exc_code = 2'd0;
    endtask

    // One clock edge for the main DUT, advancing the model with the applied inputs.
    task automatic cycle();
        bit cond_ok;
        @(posedge clk);
        edge_cnt++;
        cond_ok = bus.branch_ne ? !bus.alu_zero : bus.alu_zero;
        if (!reset) begin
            model_reset();
        end else if (m_busy) begin
            if (edge_cnt == m_load_edge) begin
                m_pc   = {24'h0, mem_byte[m_cause]};
                m_busy = 1'b0;
            end
        end else if (bus.exc_req) begin
            m_epc = m_pc - 32'd4; m_cause = bus.exc_code; start_exc();
        end else if (bus.pc_write || (bus.pc_write_cond && cond_ok)) begin
            if (bus.pc_next % 4 != 0) begin
                m_epc = m_pc - 32'd4; m_cause = 2'd0; start_exc();
            end else begin
                m_pc = bus.pc_next;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus2.pc_next = 32'h0; bus2.pc_write = 1'b0; bus2.pc_write_cond = 1'b0;
        bus2.branch_ne = 1'b0; bus2.alu_zero = 1'b0; bus2.exc_req = 1'b0; bus2.exc_code = 2'd0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want %h", bus.epc, 32'h0); end
        checks++; if (bus.exc_cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", bus.exc_cause); end
        checks++; if (bus.vec_rd !== 1'b0 || bus.vec_addr !== 32'h0) begin errors++; $display("FAIL reset_vec: got rd=%b addr=%h want 0/0", bus.vec_rd, bus.vec_addr); end
        checks++; if (bus.exc_busy !== 1'b0 || bus2.exc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0/0", bus.exc_busy, bus2.exc_busy); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_branch();
        bus.pc_write = 1'b1; bus.pc_next = 32'h40;
        cycle();
        checks++; if (bus.pc !== 32'h40 || bus.exc_busy !== 1'b0) begin errors++; $display("FAIL write_pc: got pc=%h busy=%b want 40/0", bus.pc, bus.exc_busy); end
        bus.pc_write = 1'b0; bus.pc_write_cond = 1'b1; bus.branch_ne = 1'b0; bus.alu_zero = 1'b1; bus.pc_next = 32'h80;
        cycle();
        checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL beq_taken: got %h want %h", bus.pc, 32'h80); end
        bus.alu_zero = 1'b0; bus.pc_next = 32'hC0;
        cycle();
        checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL beq_not_taken: got %h want %h", bus.pc, 32'h80); end
        bus.branch_ne = 1'b1; bus.alu_zero = 1'b1; bus.pc_next = 32'h100;
        cycle();
        checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL bne_not_taken: got %h want %h", bus.pc, 32'h80); end
        bus.alu_zero = 1'b0;
        cycle();
        checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL bne_taken: got %h want %h", bus.pc, 32'h100); end
        idle_inputs(); bus.pc_write = 1'b1; bus.pc_next = 32'h80;
        cycle();
        idle_inputs();
    endtask

    task automatic test_misalign();
        bus.pc_write = 1'b1; bus.pc_next = 32'h86;
        cycle();
        idle_inputs();
        checks++; if (bus.epc !== 32'h7C || bus.exc_cause !== 2'd0) begin errors++; $display("FAIL mis_epc: got epc=%h cause=%0d want 7c/0", bus.epc, bus.exc_cause); end
        checks++; if (bus.vec_rd !== 1'b1 || bus.vec_addr !== 32'd252) begin errors++; $display("FAIL mis_vec: got rd=%b addr=%0d want 1/252", bus.vec_rd, bus.vec_addr); end
        checks++; if (bus.pc !== 32'h80 || bus.exc_busy !== 1'b1) begin errors++; $display("FAIL mis_hold: got pc=%h busy=%b want 80/1", bus.pc, bus.exc_busy); end
        cycle();
        checks++; if (bus.vec_rd !== 1'b0 || bus.vec_addr !== 32'h0) begin errors++; $display("FAIL mis_rd_pulse: got rd=%b addr=%h want 0/0", bus.vec_rd, bus.vec_addr); end
        repeat (2) cycle();
        checks++; if (bus.pc !== 32'h80 || bus.exc_busy !== 1'b1) begin errors++; $display("FAIL mis_early: got pc=%h busy=%b want 80/1", bus.pc, bus.exc_busy); end
        cycle();
        checks++; if (bus.pc !== 32'h90 || bus.exc_busy !== 1'b0) begin errors++; $display("FAIL mis_load: got pc=%h busy=%b want 90/0", bus.pc, bus.exc_busy); end
    endtask

    task automatic test_exc_req();
        bus.exc_req = 1'b1; bus.exc_code = 2'd2; bus.pc_write = 1'b1; bus.pc_next = 32'h100;
        cycle();
        checks++; if (bus.pc !== 32'h90 || bus.epc !== 32'h8C || bus.exc_cause !== 2'd2) begin errors++; $display("FAIL exc_capture: got pc=%h epc=%h cause=%0d want 90/8c/2", bus.pc, bus.epc, bus.exc_cause); end
        checks++; if (bus.vec_rd !== 1'b1 || bus.vec_addr !== 32'd254) begin errors++; $display("FAIL exc_vec: got rd=%b addr=%0d want 1/254", bus.vec_rd, bus.vec_addr); end
        bus.exc_req = 1'b1; bus.exc_code = 2'd3; bus.pc_next = 32'h200; bus.pc_write_cond = 1'b1; bus.alu_zero = 1'b1;
        repeat (3) begin
            cycle();
            checks++; if (bus.pc !== 32'h90 || bus.epc !== 32'h8C || bus.exc_cause !== 2'd2 || bus.vec_rd !== 1'b0) begin errors++; $display("FAIL exc_ignore: got pc=%h epc=%h cause=%0d rd=%b", bus.pc, bus.epc, bus.exc_cause, bus.vec_rd); end
        end
        cycle();
        idle_inputs();
        checks++; if (bus.pc !== 32'hA4 || bus.exc_busy !== 1'b0 || bus.exc_cause !== 2'd2) begin errors++; $display("FAIL exc_load: got pc=%h busy=%b cause=%0d want a4/0/2", bus.pc, bus.exc_busy, bus.exc_cause); end
    endtask

    task automatic test_reset_mid();
        bus.exc_req = 1'b1; bus.exc_code = 2'd1;
        cycle();
        idle_inputs();
        checks++; if (bus.vec_addr !== 32'd253) begin errors++; $display("FAIL rmid_vec: got %0d want 253", bus.vec_addr); end
        cycle();
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.pc !== 32'h0 || bus.epc !== 32'h0 || bus.exc_busy !== 1'b0 || bus.exc_cause !== 2'd0) begin errors++; $display("FAIL rmid_async: got pc=%h epc=%h busy=%b cause=%0d want 0/0/0/0", bus.pc, bus.epc, bus.exc_busy, bus.exc_cause); end
        cycle();
        reset = 1'b1;
        repeat (6) begin
            cycle();
            checks++; if (bus.vec_rd !== 1'b0 || bus.pc !== 32'h0 || bus.exc_busy !== 1'b0) begin errors++; $display("FAIL rmid_dropped: got rd=%b pc=%h busy=%b want 0/0/0", bus.vec_rd, bus.pc, bus.exc_busy); end
        end
    endtask

    task automatic test_memlat1();
        bus2.pc_write = 1'b1; bus2.pc_next = 32'h22;
        @(posedge clk); #1;
        bus2.pc_write = 1'b0; bus2.pc_next = 32'h0;
        checks++; if (bus2.epc !== 32'hFFFF_FFFC || bus2.vec_rd !== 1'b1 || bus2.vec_addr !== 32'd252) begin errors++; $display("FAIL lat1_req: got epc=%h rd=%b addr=%0d want fffffffc/1/252", bus2.epc, bus2.vec_rd, bus2.vec_addr); end
        @(posedge clk); #1;
        checks++; if (bus2.vec_rd !== 1'b0 || bus2.exc_busy !== 1'b1 || bus2.pc !== 32'h0) begin errors++; $display("FAIL lat1_load_state: got rd=%b busy=%b pc=%h want 0/1/0", bus2.vec_rd, bus2.exc_busy, bus2.pc); end
        @(posedge clk); #1;
        checks++; if (bus2.pc !== 32'h90 || bus2.exc_busy !== 1'b0) begin errors++; $display("FAIL lat1_done: got pc=%h busy=%b want 90/0", bus2.pc, bus2.exc_busy); end
    endtask

    task automatic test_random();
        logic [31:0] e_addr;
        for (int i = 0; i < 4; i++) mem_byte[i] = 8'($urandom);
        for (int n = 0; n < 400; n++) begin
            bus.exc_req       = ($urandom_range(0, 15) == 0);
            bus.exc_code      = 2'($urandom_range(1, 3));
            bus.pc_write      = ($urandom_range(0, 3) == 0);
            bus.pc_write_cond = ($urandom_range(0, 3) == 0);
            bus.branch_ne     = 1'($urandom);
            bus.alu_zero      = 1'($urandom);
            bus.pc_next       = $urandom;
            if ($urandom_range(0, 3) != 0) bus.pc_next[1:0] = 2'b00;
            cycle();
            e_addr = exp_vec_rd() ? 32'd252 + {30'b0, m_cause} : 32'h0;
            checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc: cycle %0d got %h want %h", n, bus.pc, m_pc); end
            checks++; if (bus.epc !== m_epc) begin errors++; $display("FAIL rnd_epc: cycle %0d got %h want %h", n, bus.epc, m_epc); end
            checks++; if (bus.exc_cause !== m_cause) begin errors++; $display("FAIL rnd_cause: cycle %0d got %0d want %0d", n, bus.exc_cause, m_cause); end
            checks++; if (bus.exc_busy !== m_busy) begin errors++; $display("FAIL rnd_busy: cycle %0d got %b want %b", n, bus.exc_busy, m_busy); end
            checks++; if (bus.vec_rd !== exp_vec_rd() || bus.vec_addr !== e_addr) begin errors++; $display("FAIL rnd_vec: cycle %0d got rd=%b addr=%h want %b/%h", n, bus.vec_rd, bus.vec_addr, exp_vec_rd(), e_addr); end
        end
        idle_inputs();
    endtask

    initial begin
        edge_cnt = 0;
        mem_byte[0] = 8'h90; mem_byte[1] = 8'h5C; mem_byte[2] = 8'hA4; mem_byte[3] = 8'h3B;
        test_reset();
        test_branch();
        test_misalign();
        test_exc_req();
        test_reset_mid();
        test_memlat1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
